// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus between fetch and imem
interface fetch_unit_if #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 5
);
  logic               imem_req;
  logic [PC_BITS-1:0] imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [XLEN-1:0]    imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC, credit-limited imem requests, 2-entry instruction buffer
module fetch_unit #(
  parameter int          XLEN     = 32,
  parameter int          PC_BITS  = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_D,
  input  logic               EX_taken,
  input  logic [PC_BITS-1:0] EX_target,
  fetch_unit_if.master       imem,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_valid
);
  localparam logic [PC_BITS-1:0] RST_PC = PC_BITS'(RESET_PC);
  localparam logic [XLEN-1:0]    NOP    = XLEN'(32'h2000_0000);

  logic [PC_BITS-1:0] pc;
  logic [1:0]         outstanding;
  logic [1:0]         drop_cnt;
  logic [1:0]         occ;
  logic               aq_rd, aq_wr;
  logic               buf_rd, buf_wr;
  logic [PC_BITS-1:0] aq_pc    [2];
  logic [PC_BITS-1:0] buf_pc   [2];
  logic [XLEN-1:0]    buf_inst [2];

  logic       head_valid;
  logic       pop;
  logic       push;
  logic       resp;
  logic       req;
  logic       accept;
  logic [2:0] credit_used;

  // Credit counts dropped-but-outstanding requests too, so every response has a slot;
  // a same-cycle pop frees its entry early enough to keep one fetch per cycle.
  always_comb begin
    head_valid  = (occ != 2'd0);
    pop         = head_valid && !stall_D && !EX_taken;
    resp        = imem.imem_rvalid;
    push        = resp && (drop_cnt == 2'd0) && !EX_taken;
    credit_used = 3'(outstanding) + 3'(occ) - 3'(pop);
    req         = !rst && !EX_taken && (credit_used < 3'd2);
    accept      = req && imem.imem_gnt;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RST_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      occ         <= 2'd0;
      aq_rd       <= 1'b0;
      aq_wr       <= 1'b0;
      buf_rd      <= 1'b0;
      buf_wr      <= 1'b0;
    end else begin
      outstanding <= outstanding + 2'(accept) - 2'(resp);
      if (accept) aq_wr <= ~aq_wr;
      if (resp)   aq_rd <= ~aq_rd;
      if (EX_taken) begin
        // Everything still in flight after this cycle's response belongs to the old path.
        pc       <= EX_target;
        drop_cnt <= outstanding - 2'(resp);
        occ      <= 2'd0;
        buf_rd   <= 1'b0;
        buf_wr   <= 1'b0;
      end else begin
        if (accept) pc <= pc + PC_BITS'(1);
        if (resp && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
        if (push) buf_wr <= ~buf_wr;
        if (pop)  buf_rd <= ~buf_rd;
        occ <= occ + 2'(push) - 2'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) aq_pc[aq_wr] <= pc;
    if (push) begin
      buf_pc[buf_wr]   <= aq_pc[aq_rd];
      buf_inst[buf_wr] <= imem.imem_rdata;
    end
  end

  always_comb begin
    F_valid = head_valid;
    F_pc    = head_valid ? buf_pc[buf_rd]   : '0;
    F_inst  = head_valid ? buf_inst[buf_rd] : NOP;
  end
endmodule
